// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter that shares one Hack data-memory port
// (RAM16K / Screen / Keyboard map) among N requesters. Each granted access runs
// IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one cycle, ack pulse) and returns read data.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   req, we           per-requester request (held until ack) and write enable
//   addr, wdata       packed per-requester address / write data, requester i at [i*W +: W]
//   gnt               one-hot grant, high through ACCESS and RESP
//   ack               one-hot, one-cycle completion pulse in RESP
//   rdata             read data of the last completed read
//   mem_addr, mem_we, mem_wdata, mem_rdata   single-port memory interface
module mem_bus_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        we,
  input  logic [N*ADDR_W-1:0] addr,
  input  logic [N*DATA_W-1:0] wdata,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned SelW = $clog2(N);
  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [SelW-1:0] LastInit = SelW'(N - 1);
  localparam logic [CntW-1:0] CntInit  = CntW'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic [SelW-1:0]   sel_q, last_q;
  logic [CntW-1:0]   cnt_q;
  logic              op_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rdata_q;
  logic              mem_we_q;

  logic [SelW-1:0]   pick, cand;
  logic              pick_vld;
  logic [ADDR_W-1:0] addr_pick;
  logic [DATA_W-1:0] wdata_pick;
  logic              we_pick;

  // Round-robin scan starting just after the last granted requester, wrapping at N.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = SelW'((int'(last_q) + k) % int'(N));
      if (!pick_vld && req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Operand mux for the requester being picked.
  always_comb begin
    addr_pick  = '0;
    wdata_pick = '0;
    we_pick    = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (pick == SelW'(i)) begin
        addr_pick  = addr[i*ADDR_W +: ADDR_W];
        wdata_pick = wdata[i*DATA_W +: DATA_W];
        we_pick    = we[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (pick_vld) state_d = StAccess;
      StAccess: if (cnt_q == '0) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Grant / ack outputs.
  always_comb begin
    gnt = '0;
    ack = '0;
    if (state_q != StIdle) gnt[sel_q] = 1'b1;
    if (state_q == StResp) ack[sel_q] = 1'b1;
  end

  // Datapath: operands are latched once in IDLE, so requester changes afterwards are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q       <= '0;
      last_q      <= LastInit;
      cnt_q       <= '0;
      op_we_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            sel_q       <= pick;
            cnt_q       <= CntInit;
            op_we_q     <= we_pick;
            mem_addr_q  <= addr_pick;
            mem_wdata_q <= wdata_pick;
            mem_we_q    <= we_pick;
          end
        end
        StAccess: begin
          // Write strobe lasts only the first ACCESS cycle.
          mem_we_q <= 1'b0;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (!op_we_q) begin
            // Read data is valid on the last ACCESS cycle; it is presented during RESP.
            rdata_q <= mem_rdata;
          end
        end
        StResp: begin
          last_q      <= sel_q;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT with MEM_LAT=1
  logic [N-1:0]    req1 = '0, we1 = '0;
  logic [N*AW-1:0] addr1 = '0;
  logic [N*DW-1:0] wdata1 = '0;
  logic [N-1:0]    gnt1, ack1;
  logic [DW-1:0]   rdata1, mem_wdata1, mem_rdata1;
  logic [AW-1:0]   mem_addr1;
  logic            mem_we1;

  // DUT with MEM_LAT=3
  logic [N-1:0]    req3 = '0, we3 = '0;
  logic [N*AW-1:0] addr3 = '0;
  logic [N*DW-1:0] wdata3 = '0;
  logic [N-1:0]    gnt3, ack3;
  logic [DW-1:0]   rdata3, mem_wdata3, mem_rdata3;
  logic [AW-1:0]   mem_addr3;
  logic            mem_we3;

  mem_bus_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .gnt(gnt1), .ack(ack1), .rdata(rdata1), .mem_addr(mem_addr1), .mem_we(mem_we1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mem_bus_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .gnt(gnt3), .ack(ack3), .rdata(rdata3), .mem_addr(mem_addr3), .mem_we(mem_we3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Power-on contents of the memory.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 15'h4000) return 16'hBEEF;
    return {1'b0, a} ^ 16'h5A5A;
  endfunction

  // Memory for dut: writable, combinational read.
  bit [DW-1:0] mem1 [0:32767];
  bit          wr1  [0:32767];
  always @(posedge clk) begin
    if (mem_we1) begin
      mem1[mem_addr1] <= mem_wdata1;
      wr1[mem_addr1]  <= 1'b1;
    end
  end
  assign mem_rdata1 = wr1[mem_addr1] ? mem1[mem_addr1] : init_word(mem_addr1);

  // Memory for dut3: data only valid once the access has been running 3 cycles.
  int age3 = 0;
  always @(posedge clk) begin
    if (gnt3 != '0 && ack3 == '0) age3 <= age3 + 1;
    else age3 <= 0;
  end
  assign mem_rdata3 = (age3 >= 2) ? init_word(mem_addr3) : 16'hDEAD;

  // Scoreboard and reference model state.
  int n_cmp = 0;
  int n_bad = 0;
  int last_ref = N - 1;
  int last3 = N - 1;
  logic [DW-1:0] ref_rdata = '0;
  logic [DW-1:0] ref_mem [int];
  bit            fw [N];
  logic [AW-1:0] fa [N];
  logic [DW-1:0] fd [N];

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(a);
  endfunction

  task automatic set_req1(input int i, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    fw[i] = w; fa[i] = a; fd[i] = d;
    req1[i] = 1'b1;
    we1[i] = w;
    addr1[i*AW +: AW] = a;
    wdata1[i*DW +: DW] = d;
  endtask

  task automatic new_req1(input int i);
    set_req1(i, bit'($urandom_range(0, 1)), AW'($urandom_range(0, 32767)), DW'($urandom));
  endtask

  // Waits (bounded) for an ack; also gathers write-strobe and invariant observations.
  task automatic wait_ack(input bit use3, output int who, output int cyc, output int we_cnt,
                          output bit inv_bad, output logic [AW-1:0] we_addr,
                          output logic [DW-1:0] we_data);
    logic [N-1:0] g, a;
    logic mw;
    who = -1; cyc = 0; we_cnt = 0; inv_bad = 1'b0; we_addr = '0; we_data = '0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      cyc++;
      g  = use3 ? gnt3 : gnt1;
      a  = use3 ? ack3 : ack1;
      mw = use3 ? mem_we3 : mem_we1;
      if (!$onehot0(g) || !$onehot0(a) || ((a & ~g) != '0) || (mw && (g == '0 || a != '0)))
        inv_bad = 1'b1;
      if (mw) begin
        we_cnt++;
        we_addr = use3 ? mem_addr3 : mem_addr1;
        we_data = use3 ? mem_wdata3 : mem_wdata1;
      end
      if (a != '0) begin
        for (int i = 0; i < N; i++) if (a[i]) who = i;
        return;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req1 = '0; we1 = '0; req3 = '0; we3 = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_ref = N - 1;
    last3 = N - 1;
    ref_rdata = '0;
  endtask

  task automatic test_reset();
    int who, cyc, wc, acks, exp;
    bit ib;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    n_cmp++;
    if ({gnt1, ack1, rdata1, mem_addr1, mem_we1, mem_wdata1} !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h, want 0",
                        {gnt1, ack1, rdata1, mem_addr1, mem_we1, mem_wdata1});
    end
    n_cmp++;
    if ({gnt3, ack3, rdata3, mem_addr3, mem_we3, mem_wdata3} !== '0) begin
      n_bad++; $display("FAIL reset_state3: got %h, want 0",
                        {gnt3, ack3, rdata3, mem_addr3, mem_we3, mem_wdata3});
    end
    reset_n = 1'b1;
    set_req1(0, 1'b0, 15'h0123, 16'h0000);
    @(negedge clk);
    n_cmp++;
    if (gnt1 !== 4'b0001) begin
      n_bad++; $display("FAIL reset_pre_gnt: got %b, want 0001", gnt1);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt1, ack1, mem_addr1, mem_we1, mem_wdata1} !== '0) begin
      n_bad++; $display("FAIL reset_async: got %h, want 0",
                        {gnt1, ack1, mem_addr1, mem_we1, mem_wdata1});
    end
    req1 = '0;
    acks = 0;
    repeat (2) begin @(negedge clk); if (ack1 != '0) acks++; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); if (ack1 != '0) acks++; end
    n_cmp++;
    if (acks !== 0) begin
      n_bad++; $display("FAIL reset_no_ack: got %0d acks, want 0", acks);
    end
    for (int i = 0; i < N; i++) set_req1(i, 1'b0, AW'($urandom_range(0, 32767)), '0);
    exp = rr_pick(req1, last_ref);
    wait_ack(1'b0, who, cyc, wc, ib, wa, wd);
    n_cmp++;
    if (who !== exp || cyc !== 2) begin
      n_bad++; $display("FAIL reset_first_grant: got req %0d at cycle %0d, want req %0d at 2",
                        who, cyc, exp);
    end
    ref_rdata = model_read(fa[exp]);
    n_cmp++;
    if (rdata1 !== ref_rdata) begin
      n_bad++; $display("FAIL reset_first_rdata: got %h, want %h", rdata1, ref_rdata);
    end
    last_ref = exp;
    req1 = '0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    set_req1(2, 1'b0, 15'h4000, 16'h0000);
    @(negedge clk);
    n_cmp++;
    if (gnt1 !== 4'b0100 || mem_addr1 !== 15'h4000 || mem_we1 !== 1'b0) begin
      n_bad++; $display("FAIL read_access: got gnt=%b addr=%h we=%b, want 0100 4000 0",
                        gnt1, mem_addr1, mem_we1);
    end
    @(negedge clk);
    ref_rdata = model_read(15'h4000);
    n_cmp++;
    if (ack1 !== 4'b0100 || rdata1 !== ref_rdata) begin
      n_bad++; $display("FAIL read_resp: got ack=%b rdata=%h, want 0100 %h",
                        ack1, rdata1, ref_rdata);
    end
    req1 = '0;
    last_ref = 2;
    @(negedge clk);
    n_cmp++;
    if (ack1 !== 4'b0000 || gnt1 !== 4'b0000) begin
      n_bad++; $display("FAIL read_ack_pulse: got ack=%b gnt=%b, want 0000 0000", ack1, gnt1);
    end
  endtask

  task automatic test_single_write();
    int who, cyc, wc, exp;
    bit ib;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    set_req1(1, 1'b1, 15'h0010, 16'h1234);
    exp = rr_pick(req1, last_ref);
    wait_ack(1'b0, who, cyc, wc, ib, wa, wd);
    n_cmp++;
    if (who !== exp || cyc !== 2 || ib) begin
      n_bad++; $display("FAIL write_ack: got req %0d cycle %0d inv %0b, want req %0d cycle 2 inv 0",
                        who, cyc, ib, exp);
    end
    n_cmp++;
    if (wc !== 1 || wa !== 15'h0010 || wd !== 16'h1234) begin
      n_bad++; $display("FAIL write_strobe: got %0d cycles addr=%h data=%h, want 1 0010 1234",
                        wc, wa, wd);
    end
    n_cmp++;
    if (rdata1 !== ref_rdata) begin
      n_bad++; $display("FAIL write_rdata_kept: got %h, want %h", rdata1, ref_rdata);
    end
    req1 = '0; we1 = '0;
    ref_mem[16] = 16'h1234;
    last_ref = exp;
    @(negedge clk);
    set_req1(0, 1'b0, 15'h0010, 16'h0000);
    exp = rr_pick(req1, last_ref);
    wait_ack(1'b0, who, cyc, wc, ib, wa, wd);
    ref_rdata = model_read(15'h0010);
    n_cmp++;
    if (who !== exp || rdata1 !== ref_rdata) begin
      n_bad++; $display("FAIL write_readback: got req %0d rdata=%h, want req %0d rdata=%h",
                        who, rdata1, exp, ref_rdata);
    end
    last_ref = exp;
    req1 = '0;
  endtask

  task automatic test_round_robin();
    int who, cyc, wc, exp;
    bit ib;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_req1(i, 1'b0, AW'($urandom_range(0, 32767)), '0);
    for (int t = 0; t < 8; t++) begin
      exp = rr_pick(req1, last_ref);
      wait_ack(1'b0, who, cyc, wc, ib, wa, wd);
      n_cmp++;
      if (who !== exp || who !== t % N) begin
        n_bad++; $display("FAIL rr_order t=%0d: got %0d, want %0d", t, who, t % N);
      end
      n_cmp++;
      if (cyc !== ((t == 0) ? 2 : 3) || ib) begin
        n_bad++; $display("FAIL rr_spacing t=%0d: got %0d cycles inv %0b, want %0d inv 0",
                          t, cyc, ib, (t == 0) ? 2 : 3);
      end
      if (exp >= 0) begin
        ref_rdata = model_read(fa[exp]);
        last_ref = exp;
      end
      n_cmp++;
      if (rdata1 !== ref_rdata) begin
        n_bad++; $display("FAIL rr_rdata t=%0d: got %h, want %h", t, rdata1, ref_rdata);
      end
    end
    req1 = '0;
  endtask

  task automatic test_contention_wrap();
    int who, cyc, wc, exp;
    bit ib;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    @(negedge clk);
    set_req1(3, 1'b0, AW'($urandom_range(0, 32767)), '0);
    wait_ack(1'b0, who, cyc, wc, ib, wa, wd);
    n_cmp++;
    if (who !== 3) begin
      n_bad++; $display("FAIL wrap_setup: got %0d, want 3", who);
    end
    ref_rdata = model_read(fa[3]);
    last_ref = 3;
    req1 = '0;
    @(negedge clk);
    set_req1(0, 1'b0, AW'($urandom_range(0, 32767)), '0);
    set_req1(3, 1'b0, AW'($urandom_range(0, 32767)), '0);
    exp = rr_pick(req1, last_ref);
    wait_ack(1'b0, who, cyc, wc, ib, wa, wd);
    n_cmp++;
    if (who !== exp || who !== 0) begin
      n_bad++; $display("FAIL wrap_first: got %0d, want 0", who);
    end
    ref_rdata = model_read(fa[0]);
    last_ref = 0;
    req1[0] = 1'b0;
    exp = rr_pick(req1, last_ref);
    wait_ack(1'b0, who, cyc, wc, ib, wa, wd);
    n_cmp++;
    if (who !== exp || who !== 3 || cyc !== 3) begin
      n_bad++; $display("FAIL wrap_second: got req %0d cycle %0d, want req 3 cycle 3", who, cyc);
    end
    ref_rdata = model_read(fa[3]);
    n_cmp++;
    if (rdata1 !== ref_rdata) begin
      n_bad++; $display("FAIL wrap_rdata: got %h, want %h", rdata1, ref_rdata);
    end
    last_ref = 3;
    req1 = '0;
  endtask

  task automatic test_random();
    int who, cyc, wc, exp, j;
    bit ib, first;
    logic [N-1:0] pending;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    for (int r = 0; r < 25; r++) begin
      @(negedge clk);
      pending = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) if (pending[i]) new_req1(i);
      first = 1'b1;
      while (pending != '0) begin
        exp = rr_pick(pending, last_ref);
        wait_ack(1'b0, who, cyc, wc, ib, wa, wd);
        n_cmp++;
        if (who !== exp || cyc !== (first ? 2 : 3) || ib) begin
          n_bad++; $display("FAIL rand_grant r=%0d: got req %0d cycle %0d inv %0b, want req %0d cycle %0d",
                            r, who, cyc, ib, exp, first ? 2 : 3);
        end
        if (who < 0) begin
          req1 = '0; we1 = '0;
          break;
        end
        if (fw[exp]) begin
          n_cmp++;
          if (wc !== 1 || wa !== fa[exp] || wd !== fd[exp] || rdata1 !== ref_rdata) begin
            n_bad++; $display("FAIL rand_write r=%0d: got %0d strobes %h/%h rdata %h, want 1 %h/%h %h",
                              r, wc, wa, wd, rdata1, fa[exp], fd[exp], ref_rdata);
          end
          ref_mem[int'(fa[exp])] = fd[exp];
        end else begin
          ref_rdata = model_read(fa[exp]);
          n_cmp++;
          if (wc !== 0 || rdata1 !== ref_rdata) begin
            n_bad++; $display("FAIL rand_read r=%0d: got %0d strobes rdata %h, want 0 %h",
                              r, wc, rdata1, ref_rdata);
          end
        end
        last_ref = exp;
        pending[exp] = 1'b0;
        req1[exp] = 1'b0;
        we1[exp] = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          j = int'($urandom_range(0, N - 1));
          if (!pending[j]) begin
            new_req1(j);
            pending[j] = 1'b1;
          end
        end
        first = 1'b0;
      end
    end
    req1 = '0; we1 = '0;
  endtask

  task automatic test_abandon_latency();
    int who, cyc, wc, exp;
    bit ib;
    logic [AW-1:0] a0, wa;
    logic [DW-1:0] d0, wd;
    logic [DW-1:0] want;
    @(negedge clk);
    a0 = AW'($urandom_range(0, 32767));
    d0 = DW'($urandom);
    req3[0] = 1'b1; we3[0] = 1'b0; addr3[0 +: AW] = a0; wdata3[0 +: DW] = d0;
    @(negedge clk);
    n_cmp++;
    if (gnt3 !== 4'b0001 || mem_addr3 !== a0 || mem_we3 !== 1'b0 || mem_wdata3 !== d0) begin
      n_bad++; $display("FAIL lat3_access: got gnt=%b addr=%h we=%b wd=%h, want 0001 %h 0 %h",
                        gnt3, mem_addr3, mem_we3, mem_wdata3, a0, d0);
    end
    req3[0] = 1'b0;  // abandoned during ACCESS
    wait_ack(1'b1, who, cyc, wc, ib, wa, wd);
    n_cmp++;
    if (who !== 0 || cyc + 1 !== 4 || ib) begin
      n_bad++; $display("FAIL lat3_abandon_ack: got req %0d at cycle %0d inv %0b, want req 0 at 4",
                        who, cyc + 1, ib);
    end
    want = init_word(a0);
    n_cmp++;
    if (rdata3 !== want) begin
      n_bad++; $display("FAIL lat3_rdata: got %h, want %h", rdata3, want);
    end
    last3 = 0;
    @(negedge clk);
    @(negedge clk);
    req3 = 4'b0101;
    addr3[0 +: AW] = a0;
    addr3[2*AW +: AW] = AW'($urandom_range(0, 32767));
    for (int t = 0; t < 2; t++) begin
      exp = rr_pick(req3, last3);
      wait_ack(1'b1, who, cyc, wc, ib, wa, wd);
      n_cmp++;
      if (who !== exp || cyc !== ((t == 0) ? 4 : 5) || wc !== 0 || ib) begin
        n_bad++; $display("FAIL lat3_b2b t=%0d: got req %0d cycle %0d strobes %0d, want req %0d cycle %0d 0",
                          t, who, cyc, wc, exp, (t == 0) ? 4 : 5);
      end
      if (exp >= 0) begin
        want = init_word(addr3[exp*AW +: AW]);
        req3[exp] = 1'b0;
        last3 = exp;
      end
      n_cmp++;
      if (rdata3 !== want) begin
        n_bad++; $display("FAIL lat3_b2b_rdata t=%0d: got %h, want %h", t, rdata3, want);
      end
    end
    req3 = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_contention_wrap();
    test_random();
    test_abandon_latency();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
